// File: rtl/cfxp_div_pkg.sv
// Shared types for the complex fixed-point arithmetic units (add/mult/div).
package cfxp_div_pkg;

   typedef enum logic [1:0] {OP_ADD, OP_MULT, OP_DIV} fpu_op_t;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} cdiv_state_t;

endpackage

// File: rtl/fxp_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and emit the quotient bit.
module fxp_udiv_step #(
   parameter int SW = 64
) (
   input  logic [SW-1:0] rem,
   input  logic          bit_in,
   input  logic [SW-1:0] div,
   output logic [SW-1:0] rem_nx,
   output logic          q
);

   logic [SW:0] trial;

   assign trial  = {rem, bit_in};
   assign q      = trial >= {1'b0, div};
   assign rem_nx = q ? SW'(trial - {1'b0, div}) : trial[SW-1:0];

endmodule

// File: rtl/cfxp_div.sv
// Sequential complex fixed-point divider Q = A*conj(B) / |B|^2.
// state | meaning
// IDLE  | in_ready high, waiting for operands
// MUL   | form NR, NI, D; magnitudes, signs, overflow / divide-by-zero flags
// DIV   | one restoring step per cycle on both components, shared divisor
// DONE  | result held with out_valid until out_ready
module cfxp_div
   import cfxp_div_pkg::*;
#(
   parameter int n_int  = 8,
   parameter int n_mant = 23
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [n_int+n_mant:0] AR,
   input  logic signed [n_int+n_mant:0] AI,
   input  logic signed [n_int+n_mant:0] BR,
   input  logic signed [n_int+n_mant:0] BI,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [n_int+n_mant:0] resultR,
   output logic signed [n_int+n_mant:0] resultI,
   output logic                        div_zero,
   output logic                        ovf
);

   localparam int n_tot = n_int + n_mant;
   localparam int W     = n_tot + 1;
   localparam int PW    = 2 * W + 1;
   localparam int RW    = 2 * W;
   localparam int CW    = $clog2(n_tot + 1);
   localparam logic [W-1:0] q_max = {1'b0, {n_tot{1'b1}}};
   localparam logic [W-1:0] q_min = {1'b1, {n_tot{1'b0}}};

   cdiv_state_t         state;
   logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
   logic [CW-1:0]       cnt;
   logic [RW-1:0]       d_q, remr_q, remi_q;
   logic [W-1:0]        shr_q, shi_q;
   logic                negr_q, negi_q, nzr_q, nzi_q, ovfr_q, ovfi_q, divz_q;

   logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x, nr, ni;
   logic [PW-1:0]        nr_mag, ni_mag;
   logic [W-1:0]         br_mag, bi_mag;
   logic [RW-1:0]        d;
   logic                 ovfr_c, ovfi_c;

   always_comb begin
      ar_x   = PW'(ar_q);
      ai_x   = PW'(ai_q);
      br_x   = PW'(br_q);
      bi_x   = PW'(bi_q);
      nr     = ar_x * br_x + ai_x * bi_x;
      ni     = ai_x * br_x - ar_x * bi_x;
      nr_mag = nr[PW-1] ? -nr : nr;
      ni_mag = ni[PW-1] ? -ni : ni;
      br_mag = br_q[W-1] ? -br_q : br_q;
      bi_mag = bi_q[W-1] ? -bi_q : bi_q;
      d      = RW'(br_mag) * RW'(br_mag) + RW'(bi_mag) * RW'(bi_mag);
      // |N|<<n_mant >= D<<n_tot reduces to |N| >= D<<n_int
      ovfr_c = {{n_int{1'b0}}, nr_mag} >= {1'b0, d, {n_int{1'b0}}};
      ovfi_c = {{n_int{1'b0}}, ni_mag} >= {1'b0, d, {n_int{1'b0}}};
   end

   logic [RW-1:0] remr_nx, remi_nx;
   logic          qr_bit, qi_bit;

   fxp_udiv_step #(.SW(RW)) u_step_r (
      .rem    (remr_q),
      .bit_in (shr_q[W-1]),
      .div    (d_q),
      .rem_nx (remr_nx),
      .q      (qr_bit)
   );

   fxp_udiv_step #(.SW(RW)) u_step_i (
      .rem    (remi_q),
      .bit_in (shi_q[W-1]),
      .div    (d_q),
      .rem_nx (remi_nx),
      .q      (qi_bit)
   );

   function automatic logic [W-1:0] finish_q(input logic sat, input logic neg,
                                             input logic nz, input logic [W-1:0] q);
      if (sat)
         return !nz ? '0 : (neg ? q_min : q_max);
      return neg ? -q : q;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         resultR   <= '0;
         resultI   <= '0;
         div_zero  <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         ar_q      <= '0;
         ai_q      <= '0;
         br_q      <= '0;
         bi_q      <= '0;
         d_q       <= '0;
         remr_q    <= '0;
         remi_q    <= '0;
         shr_q     <= '0;
         shi_q     <= '0;
         negr_q    <= 1'b0;
         negi_q    <= 1'b0;
         nzr_q     <= 1'b0;
         nzi_q     <= 1'b0;
         ovfr_q    <= 1'b0;
         ovfi_q    <= 1'b0;
         divz_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               ar_q     <= AR;
               ai_q     <= AI;
               br_q     <= BR;
               bi_q     <= BI;
               in_ready <= 1'b0;
               state    <= MUL;
            end
            MUL: begin
               d_q    <= d;
               divz_q <= (d == '0);
               // with D == 0 the numerators vanish, so the infinite quotient takes A's sign
               if (d == '0) begin
                  negr_q <= ar_q[W-1];
                  negi_q <= ai_q[W-1];
                  nzr_q  <= |ar_q;
                  nzi_q  <= |ai_q;
               end else begin
                  negr_q <= nr[PW-1];
                  negi_q <= ni[PW-1];
                  nzr_q  <= |nr;
                  nzi_q  <= |ni;
               end
               ovfr_q <= ovfr_c;
               ovfi_q <= ovfi_c;
               remr_q <= RW'(nr_mag >> (n_int + 1));
               remi_q <= RW'(ni_mag >> (n_int + 1));
               shr_q  <= {nr_mag[n_int:0], {n_mant{1'b0}}};
               shi_q  <= {ni_mag[n_int:0], {n_mant{1'b0}}};
               cnt    <= CW'(n_tot);
               state  <= DIV;
            end
            DIV: begin
               remr_q <= remr_nx;
               remi_q <= remi_nx;
               shr_q  <= {shr_q[W-2:0], qr_bit};
               shi_q  <= {shi_q[W-2:0], qi_bit};
               if (cnt == '0) begin
                  resultR   <= finish_q(divz_q | ovfr_q, negr_q, nzr_q, {shr_q[W-2:0], qr_bit});
                  resultI   <= finish_q(divz_q | ovfi_q, negi_q, nzi_q, {shi_q[W-2:0], qi_bit});
                  div_zero  <= divz_q;
                  ovf       <= divz_q | ovfr_q | ovfi_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfxp_div.sv
// Directed bench for cfxp_div at default format (1.0 = 0x0080_0000).
module tb_cfxp_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
   logic [31:0] AR, AI, BR, BI, resultR, resultI;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cfxp_div dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .AR        (AR),
      .AI        (AI),
      .BR        (BR),
      .BI        (BI),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .resultR   (resultR),
      .resultI   (resultI),
      .div_zero  (div_zero),
      .ovf       (ovf)
   );

   typedef struct {
      logic [31:0] ar, ai, br, bi, er, ei;
      logic        dz, ov;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] ar, ai, br, bi);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_before_op", 32'(in_ready), 32'd1);
      AR = ar; AI = ai; BR = br; BI = bi;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic release_op(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_result(input string tag, input vec_t v, input int lat);
      chk({tag, "_latency"}, 32'(lat), 32'd33);
      chk({tag, "_re"}, resultR, v.er);
      chk({tag, "_im"}, resultI, v.ei);
      chk({tag, "_div_zero"}, 32'(div_zero), 32'(v.dz));
      chk({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   lat;

      in_valid  = 1'b0;
      out_ready = 1'b0;
      AR = '0; AI = '0; BR = '0; BI = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_re", resultR, 32'h0);
      chk("rst_im", resultI, 32'h0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      // (1+j0)/(1+j0)
      vecs.push_back('{32'h0080_0000, 32'h0, 32'h0080_0000, 32'h0, 32'h0080_0000, 32'h0, 1'b0, 1'b0});
      // (2+j4)/(1+j1) = 3+j1
      vecs.push_back('{32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 32'h0080_0000,
                       32'h0180_0000, 32'h0080_0000, 1'b0, 1'b0});
      // (-1)/(3) truncates toward zero
      vecs.push_back('{32'hFF80_0000, 32'h0, 32'h0180_0000, 32'h0, 32'hFFD5_5556, 32'h0, 1'b0, 1'b0});
      // (1-j1)/0
      vecs.push_back('{32'h0080_0000, 32'hFF80_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1});
      // 0/(1)
      vecs.push_back('{32'h0, 32'h0, 32'h0080_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
      // 1/j = -j
      vecs.push_back('{32'h0080_0000, 32'h0, 32'h0, 32'h0080_0000, 32'h0, 32'hFF80_0000, 1'b0, 1'b0});
      // -256/1: quotient hits 2^n_tot, saturates to the negative limit
      vecs.push_back('{32'h8000_0000, 32'h0, 32'h0080_0000, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b1});
      // largest positive / 1 just fits
      vecs.push_back('{32'h7FFF_FFFF, 32'h0, 32'h0080_0000, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         v = vecs[i];
         start_op(v.ar, v.ai, v.br, v.bi);
         wait_done(lat);
         check_result($sformatf("v%0d", i), v, lat);
         release_op($sformatf("v%0d", i));
      end

      // 100 / (raw 1): overflow, then stall the consumer with a new request pending
      v = '{32'h3200_0000, 32'h0, 32'h0000_0001, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1};
      start_op(v.ar, v.ai, v.br, v.bi);
      wait_done(lat);
      check_result("sat", v, lat);
      AR = 32'h0080_0000; AI = 32'h0; BR = 32'h0080_0000; BI = 32'h0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
         chk($sformatf("hold%0d_re", k), resultR, 32'h7FFF_FFFF);
         chk($sformatf("hold%0d_im", k), resultI, 32'h0);
         chk($sformatf("hold%0d_ovf", k), 32'(ovf), 32'd1);
      end
      in_valid = 1'b0;
      release_op("sat");

      // abort after ten division steps
      start_op(32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 32'h0080_0000);
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_re", resultR, 32'h0);
      chk("abort_im", resultI, 32'h0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      chk("abort_div_zero", 32'(div_zero), 32'd0);

      // (1+j2)/2 = 0.5+j1
      v = '{32'h0080_0000, 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0040_0000, 32'h0080_0000, 1'b0, 1'b0};
      start_op(v.ar, v.ai, v.br, v.bi);
      wait_done(lat);
      check_result("post_abort", v, lat);
      release_op("post_abort");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
